rr_arbiter8: RTL and testbench

//  Round-robin arbiter that shares one 8-bit datapath resource between 8 requesters.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick8.sv | 29 ++
 rtl/rr_arbiter8.sv | 118 +++++++++++
 tb/tb_rr_arbiter8.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// The pick helper and the top-level FSM both import this package.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping mod 8.
// The request vector is rotated so ptr sits at bit 0, the lowest set bit is encoded, then ptr is added back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  pick,
  output logic             any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [ID_W-1:0]    offset;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: N_REQ];
    offset  = '0;
    // Scanning downward leaves the lowest set index as the final value.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = ID_W'(i);
    end
    pick = offset + ptr;
    any  = |req;
  end

endmodule : rr_pick8

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters: exclusive registered grant, release on done or req drop,
// forced release after MAX_HOLD cycles, and GAP idle turnaround cycles between owners.
module rr_arbiter8
  import arb_pkg::N_REQ, arb_pkg::ID_W, arb_pkg::arb_state_t, arb_pkg::IDLE, arb_pkg::OWN;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned GAP      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [1:0] GAP_CNT    = 2'(GAP);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [7:0]       hold_q, hold_d;
  logic [1:0]       gap_q, gap_d;

  logic [ID_W-1:0]  pick;
  logic             any;
  logic             at_limit;
  logic             owner_rel;

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    timeout   = 1'b0;
    at_limit  = (hold_q == HOLD_LIMIT);
    owner_rel = done[id_q] || !req[id_q];

    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = OWN;
          id_d    = pick;
          gnt_d   = N_REQ'(1) << pick;
          valid_d = 1'b1;
          hold_d  = 8'd1;
          ptr_d   = pick + ID_W'(1);
        end
      end

      OWN: begin
        if (owner_rel || at_limit) begin
          // A voluntary release in the limit cycle is a normal release, not a timeout.
          timeout = at_limit && !owner_rel;
          gnt_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
          if (GAP > 0) begin
            state_d = arb_pkg::GAP;
            gap_d   = GAP_CNT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      arb_pkg::GAP: begin
        gap_d = gap_q - 2'd1;
        if (gap_q == 2'd1) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 (MAX_HOLD=16, GAP=1): directed vector table,
// reset-during-grant sequence, and a randomised run against a cycle-level reference model.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;
  localparam int GAP      = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] done;
    logic       valid;
    logic [2:0] id;
    logic       tmo;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [2:0] id;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] d, input logic v,
                     input logic [2:0] id, input logic t);
    vec_t e;
    e.req = r; e.done = d; e.valid = v; e.id = id; e.tmo = t;
    tbl.push_back(e);
  endtask

  // Called shortly after a rising edge: drive inputs, check the combinational timeout,
  // queue the registered outcome, then compare it after the next edge.
  task automatic drive_cycle(input logic [7:0] r, input logic [7:0] d, input logic ev,
                             input logic [2:0] eid, input logic etmo, input string name);
    exp_t e;
    logic [7:0] egnt;
    req  = r;
    done = d;
    #1;
    check({name, " timeout"}, 32'(timeout), 32'(etmo));
    e.valid = ev; e.id = eid; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, " scoreboard underflow"}, 32'(1), 32'(0));
    end else begin
      e    = sb.pop_front();
      egnt = e.valid ? (8'(1) << e.id) : 8'h00;
      check({e.name, " gnt_valid"}, 32'(gnt_valid), 32'(e.valid));
      check({e.name, " gnt"}, 32'(gnt), 32'(egnt));
      if (e.valid) check({e.name, " gnt_id"}, 32'(gnt_id), 32'(e.id));
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    #1;
    check("reset gnt", 32'(gnt), 32'(0));
    check("reset gnt_valid", 32'(gnt_valid), 32'(0));
    check("reset gnt_id", 32'(gnt_id), 32'(0));
    check("reset timeout", 32'(timeout), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state for the randomised phase.
  int         m_st, m_ptr, m_id, m_hold, m_gap;
  logic [7:0] rq, dq;
  logic       etmo, rel;
  int         idx;

  initial begin
    // Rotation: all requesting, owner pulses done the cycle after each grant.
    for (int k = 0; k < 9; k++) begin
      add(8'hFF, 8'h00,               1'b1, 3'(k % 8), 1'b0);
      add(8'hFF, 8'(1) << (k % 8),    1'b0, 3'd0,      1'b0);
      add(8'hFF, 8'h00,               1'b0, 3'd0,      1'b0);
    end
    // Wrap: move ptr to 6, then requesters 6 and 0 alternate.
    add(8'h20, 8'h00, 1'b1, 3'd5, 1'b0);
    add(8'h20, 8'h20, 1'b0, 3'd0, 1'b0);
    add(8'h41, 8'h00, 1'b0, 3'd0, 1'b0);
    add(8'h41, 8'h00, 1'b1, 3'd6, 1'b0);
    add(8'h41, 8'h40, 1'b0, 3'd0, 1'b0);
    add(8'h41, 8'h00, 1'b0, 3'd0, 1'b0);
    add(8'h41, 8'h00, 1'b1, 3'd0, 1'b0);
    add(8'h01, 8'h01, 1'b0, 3'd0, 1'b0);
    add(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    add(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    // Foreign done is ignored; owner dropping req releases; done outside OWN is ignored.
    add(8'h04, 8'h00, 1'b1, 3'd2, 1'b0);
    add(8'h04, 8'h10, 1'b1, 3'd2, 1'b0);
    add(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    add(8'h00, 8'hFF, 1'b0, 3'd0, 1'b0);
    add(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    // Timeout: requester 3 holds for MAX_HOLD cycles, then is revoked.
    add(8'h08, 8'h00, 1'b1, 3'd3, 1'b0);
    for (int k = 0; k < MAX_HOLD - 1; k++) add(8'h08, 8'h00, 1'b1, 3'd3, 1'b0);
    add(8'h08, 8'h00, 1'b0, 3'd0, 1'b1);
    add(8'h08, 8'h00, 1'b0, 3'd0, 1'b0);
    // Coincident: done arrives exactly at the limit, so no timeout.
    add(8'h08, 8'h00, 1'b1, 3'd3, 1'b0);
    for (int k = 0; k < MAX_HOLD - 1; k++) add(8'h08, 8'h00, 1'b1, 3'd3, 1'b0);
    add(8'h08, 8'h08, 1'b0, 3'd0, 1'b0);
    add(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    add(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    apply_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      drive_cycle(tbl[i].req, tbl[i].done, tbl[i].valid, tbl[i].id, tbl[i].tmo,
                  $sformatf("vec%0d", i));
    end

    // Reset mid-grant: outputs clear immediately and ptr returns to 0.
    drive_cycle(8'h20, 8'h00, 1'b1, 3'd5, 1'b0, "pre-reset grant");
    rst_n = 1'b0;
    #1;
    check("async reset gnt", 32'(gnt), 32'(0));
    check("async reset gnt_valid", 32'(gnt_valid), 32'(0));
    check("async reset timeout", 32'(timeout), 32'(0));
    req = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(8'h41, 8'h00, 1'b1, 3'd0, 1'b0, "post-reset ptr");

    // Randomised run against the reference model, starting from a fresh reset.
    apply_reset();
    m_st = 0; m_ptr = 0; m_id = 0; m_hold = 0; m_gap = 0;
    rq = 8'h00;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
      end
      dq = 8'h00;
      if ($urandom_range(0, 9) == 0) dq = 8'(1) << m_id;
      else if ($urandom_range(0, 9) == 0) dq = 8'(1) << $urandom_range(0, 7);

      rel  = (m_st == 1) && (dq[m_id] || !rq[m_id] || m_hold >= MAX_HOLD);
      etmo = (m_st == 1) && (m_hold >= MAX_HOLD) && !dq[m_id] && rq[m_id];

      if (m_st == 0) begin
        idx = -1;
        for (int k = 0; k < 8; k++) begin
          if (idx < 0 && rq[(m_ptr + k) % 8]) idx = (m_ptr + k) % 8;
        end
        if (idx >= 0) begin
          m_st = 1; m_id = idx; m_ptr = (idx + 1) % 8; m_hold = 1;
        end
      end else if (m_st == 1) begin
        if (rel) begin
          m_st  = (GAP > 0) ? 2 : 0;
          m_gap = GAP;
        end else begin
          m_hold++;
        end
      end else begin
        if (m_gap == 1) m_st = 0;
        m_gap--;
      end

      drive_cycle(rq, dq, m_st == 1, 3'(m_id), etmo, $sformatf("rand%0d", c));
    end

    check("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rr_arbiter8
